// File: rtl/vram_tile_write_arbiter.sv
// Two-master tile write arbiter: round-robin grant of whole 16-word tile bursts,
// producing a registered write strobe, address and data for the tile memory.
module vram_tile_write_arbiter #(
  parameter int TILE_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [TILE_W-1:0] m0_tile,
  input  logic [TILE_W-1:0] m1_tile,
  input  logic              m0_valid,
  input  logic              m1_valid,
  input  logic [15:0]       m0_data,
  input  logic [15:0]       m1_data,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m0_done,
  output logic              m1_done,
  input  logic              hold,
  output logic [TILE_W+3:0] write_addr,
  output logic [15:0]       write_data,
  output logic              write_enable,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_s;
  logic                ptr_r;
  logic                ptr_s;
  logic                sel_r;
  logic                sel_s;
  logic [TILE_W-1:0]   tile_r;
  logic [TILE_W-1:0]   tile_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic                accept_s;
  logic [15:0]         word_s;

  logic                grant0_r;
  logic                grant1_r;
  logic                done0_r;
  logic                done1_r;
  logic                busy_r;
  logic                we_r;
  logic [TILE_W+3:0]   addr_r;
  logic [15:0]         data_r;

  // Next-state logic: arbitration in IDLE, word counting in BURST, one-cycle DONE.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    sel_s    = sel_r;
    tile_s   = tile_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    word_s   = sel_r ? m1_data : m0_data;
    case (state_r)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // A lone requester wins outright; the pointer only breaks ties.
          sel_s   = (m0_req && m1_req) ? ptr_r : m1_req;
          tile_s  = sel_s ? m1_tile : m0_tile;
          cnt_s   = 4'd0;
          state_s = ST_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        accept_s = !hold && (sel_r ? m1_valid : m0_valid);
        if (accept_s) begin
          cnt_s = cnt_r + 4'd1;
          if (cnt_r == 4'hF) begin
            state_s = ST_DONE;
            ptr_s   = ~sel_r;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= 1'b0;
      sel_r   <= 1'b0;
      tile_r  <= '0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      tile_r  <= tile_s;
      cnt_r   <= cnt_s;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant0_r <= 1'b0;
      grant1_r <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      grant0_r <= (state_s == ST_BURST) && !sel_s;
      grant1_r <= (state_s == ST_BURST) && sel_s;
      done0_r  <= (state_s == ST_DONE) && !sel_s;
      done1_r  <= (state_s == ST_DONE) && sel_s;
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  // Write port: address and data hold their last value between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      data_r <= 16'h0000;
    end else begin
      we_r <= accept_s;
      if (accept_s) begin
        addr_r <= {tile_r, cnt_r};
        data_r <= word_s;
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  assign m0_ready     = grant0_r && !hold;
  assign m1_ready     = grant1_r && !hold;
  assign m0_grant     = grant0_r;
  assign m1_grant     = grant1_r;
  assign m0_done      = done0_r;
  assign m1_done      = done1_r;
  assign busy         = busy_r;
  assign write_enable = we_r;
  assign write_addr   = addr_r;
  assign write_data   = data_r;

endmodule

// File: tb/tb_vram_tile_write_arbiter.sv
// Bench for vram_tile_write_arbiter: vector table, directed burst corner cases,
// and random traffic checked against a transaction-level reference model.
module tb_vram_tile_write_arbiter;
  localparam int TW = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic m0_req = 1'b0, m1_req = 1'b0;
  logic [TW-1:0] m0_tile = '0, m1_tile = '0;
  logic m0_valid = 1'b0, m1_valid = 1'b0;
  logic [15:0] m0_data = 16'h0, m1_data = 16'h0;
  logic hold = 1'b0;
  logic m0_ready, m1_ready, m0_grant, m1_grant, m0_done, m1_done;
  logic [TW+3:0] write_addr;
  logic [15:0] write_data;
  logic write_enable, busy;

  always #5 clk = ~clk;

  vram_tile_write_arbiter #(.TILE_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_tile(m0_tile), .m1_tile(m1_tile),
    .m0_valid(m0_valid), .m1_valid(m1_valid), .m0_data(m0_data), .m1_data(m1_data),
    .m0_ready(m0_ready), .m1_ready(m1_ready), .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_done(m0_done), .m1_done(m1_done), .hold(hold),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 streaming, 2 finished; owner and words taken.
  int ph, own, nw, ptr;
  logic [TW-1:0] tl;
  logic e_we;
  logic [TW+3:0] e_addr;
  logic [15:0] e_data;
  int sent[2];

  logic [TW+3:0] wa_log[$];
  logic [15:0] wd_log[$];
  int g_log[$];
  logic prev_g0, prev_g1;
  logic done_seen;

  typedef struct {
    logic req0; logic [TW-1:0] tile0; logic valid0; logic [15:0] data0;
    logic e_grant0; logic e_ready0; logic e_done0; logic e_busy;
    logic e_we; logic [TW+3:0] e_addr; logic [15:0] e_data;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; own = 0; nw = 0; ptr = 0; tl = '0;
    e_we = 1'b0; e_addr = '0; e_data = 16'h0;
    sent[0] = 0; sent[1] = 0;
    prev_g0 = 1'b0; prev_g1 = 1'b0; done_seen = 1'b0;
  endtask

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); g_log.delete();
    sent[0] = 0; sent[1] = 0;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    m0_tile = '0; m1_tile = '0; m0_data = 16'h0; m1_data = 16'h0; hold = 1'b0;
  endtask

  // One clock: check ready against current inputs, advance the model, check registered outputs.
  task automatic tick();
    logic acc;
    #1;
    chk("m0_ready", m0_ready, (ph == 1 && own == 0 && !hold));
    chk("m1_ready", m1_ready, (ph == 1 && own == 1 && !hold));
    acc = 1'b0;
    if (ph == 0) begin
      if (m0_req || m1_req) begin
        own = (m0_req && m1_req) ? ptr : (m1_req ? 1 : 0);
        tl = (own == 1) ? m1_tile : m0_tile;
        nw = 0;
        ph = 1;
      end
    end else if (ph == 1) begin
      acc = !hold && ((own == 1) ? m1_valid : m0_valid);
      if (acc) begin
        e_addr = {tl, 4'(nw)};
        e_data = (own == 1) ? m1_data : m0_data;
        sent[own]++;
        nw++;
        if (nw == 16) begin
          ph = 2;
          ptr = 1 - own;
        end
      end
    end else begin
      ph = 0;
    end
    e_we = acc;
    @(posedge clk); #2;
    chk("m0_grant", m0_grant, (ph == 1 && own == 0));
    chk("m1_grant", m1_grant, (ph == 1 && own == 1));
    chk("m0_done", m0_done, (ph == 2 && own == 0));
    chk("m1_done", m1_done, (ph == 2 && own == 1));
    chk("busy", busy, (ph != 0));
    chk("write_enable", write_enable, e_we);
    chk("write_addr", write_addr, e_addr);
    chk("write_data", write_data, e_data);
    if (write_enable) begin
      wa_log.push_back(write_addr);
      wd_log.push_back(write_data);
    end
    if (m0_grant && !prev_g0) g_log.push_back(0);
    if (m1_grant && !prev_g1) g_log.push_back(1);
    prev_g0 = m0_grant;
    prev_g1 = m1_grant;
    done_seen = m0_done || m1_done;
  endtask

  // Asynchronous reset mid-cycle; all outputs must clear before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_m0_ready", m0_ready, 1'b0);
    chk("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_grants", {m0_grant, m1_grant}, 2'b00);
    chk("rst_dones", {m0_done, m1_done}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_addr", write_addr, 15'h0000);
    chk("rst_data", write_data, 16'h0000);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cyc, hold_cnt, b2b, found;
    logic prev_we;
    logic rq[2];
    logic [TW-1:0] tq[2];

    // Single-burst vector table: cycle 1 is the request cycle.
    for (int i = 1; i < 20; i++) begin
      tbl[i].req0     = (i == 1);
      tbl[i].tile0    = 11'h005;
      tbl[i].valid0   = (i <= 17);
      tbl[i].data0    = (i >= 2) ? 16'h1000 + 16'(i - 2) : 16'h0000;
      tbl[i].e_grant0 = (i >= 2 && i <= 17);
      tbl[i].e_ready0 = (i >= 2 && i <= 17);
      tbl[i].e_done0  = (i == 18);
      tbl[i].e_busy   = (i >= 2 && i <= 18);
      tbl[i].e_we     = (i >= 3 && i <= 18);
      tbl[i].e_addr   = (i < 3) ? 15'h0000 : ((i <= 18) ? 15'h0050 + 15'(i - 3) : 15'h005F);
      tbl[i].e_data   = (i < 3) ? 16'h0000 : ((i <= 18) ? 16'h1000 + 16'(i - 3) : 16'h100F);
    end

    idle_inputs();
    #3;
    do_reset();
    for (int i = 1; i < 20; i++) begin
      chk("tbl_grant0", m0_grant, tbl[i].e_grant0);
      chk("tbl_grant1", m1_grant, 1'b0);
      chk("tbl_done0", m0_done, tbl[i].e_done0);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_we", write_enable, tbl[i].e_we);
      chk("tbl_addr", write_addr, tbl[i].e_addr);
      chk("tbl_data", write_data, tbl[i].e_data);
      m0_req = tbl[i].req0; m0_tile = tbl[i].tile0;
      m0_valid = tbl[i].valid0; m0_data = tbl[i].data0;
      #1;
      chk("tbl_ready0", m0_ready, tbl[i].e_ready0);
      @(posedge clk); #2;
    end

    // Simultaneous requests after reset: m0, m1, then m0 again.
    idle_inputs();
    do_reset();
    clear_logs();
    m0_req = 1'b1; m1_req = 1'b1; m0_tile = 11'h001; m1_tile = 11'h002;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      m0_data = 16'hA000 + 16'(sent[0]);
      m1_data = 16'hB000 + 16'(sent[1]);
      tick();
    end
    idle_inputs();
    tick(); tick();
    chk("simul_grant_count", g_log.size(), 3);
    if (g_log.size() >= 3) begin
      chk("simul_first", g_log[0], 0);
      chk("simul_second", g_log[1], 1);
      chk("simul_third", g_log[2], 0);
    end
    chk("simul_write_count", wa_log.size(), 48);
    if (wa_log.size() >= 48) begin
      chk("simul_m0_first", wa_log[0], 15'h0010);
      chk("simul_m0_last", wa_log[15], 15'h001F);
      chk("simul_m1_first", wa_log[16], 15'h0020);
      chk("simul_m1_last", wa_log[31], 15'h002F);
      chk("simul_m1_data", wd_log[16], 16'hB000);
      chk("simul_m0_again", wa_log[32], 15'h0010);
    end

    // Hold stall of 3 cycles after word 7 on tile 7FF.
    clear_logs();
    m0_tile = 11'h7FF; m0_valid = 1'b1;
    hold_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 26; c++) begin
      m0_req = (c == 1);
      m0_data = 16'hC000 + 16'(sent[0]);
      hold = (sent[0] >= 8 && hold_cnt < 3);
      if (hold) hold_cnt++;
      tick();
      if (done_seen && done_cyc == 0) done_cyc = c + 1;
    end
    idle_inputs();
    chk("hold_done_cycle", done_cyc, 21);
    chk("hold_write_count", wa_log.size(), 16);
    for (int i = 0; i < wa_log.size() && i < 16; i++)
      chk("hold_addr_seq", wa_log[i], 15'h7FF0 + 15'(i));

    // Foreign valid from master 1 during a master 0 burst.
    clear_logs();
    m0_tile = 11'h003; m0_valid = 1'b1; m1_valid = 1'b1; m1_data = 16'hDEAD;
    for (int c = 1; c <= 20; c++) begin
      m0_req = (c == 1);
      m0_data = 16'h2000 + 16'(sent[0]);
      tick();
    end
    idle_inputs();
    found = 0;
    foreach (wd_log[i]) if (wd_log[i] == 16'hDEAD) found++;
    chk("foreign_dead_written", found, 0);
    chk("foreign_write_count", wa_log.size(), 16);

    // Valid on alternate cycles.
    clear_logs();
    m0_tile = 11'h0AB; done_cyc = 0; b2b = 0; prev_we = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      m0_req = (c == 1);
      m0_valid = (c % 2 == 0);
      m0_data = 16'h3000 + 16'(sent[0]);
      tick();
      if (done_seen && done_cyc == 0) done_cyc = c + 1;
      if (write_enable && prev_we) b2b++;
      prev_we = write_enable;
    end
    idle_inputs();
    chk("gap_done_cycle", done_cyc, 33);
    chk("gap_write_count", wa_log.size(), 16);
    chk("gap_back_to_back", b2b, 0);
    if (wa_log.size() >= 16) chk("gap_last_addr", wa_log[15], 15'h0ABF);

    // Reset after word 5, then master 1 alone.
    clear_logs();
    m0_tile = 11'h004; m0_valid = 1'b1;
    for (int c = 1; c <= 20 && sent[0] < 6; c++) begin
      m0_req = (c == 1);
      m0_data = 16'h4000 + 16'(sent[0]);
      tick();
    end
    chk("rstmid_words_before", sent[0], 6);
    chk("rstmid_last_written", write_addr, 15'h0045);
    idle_inputs();
    clear_logs();
    m1_req = 1'b1; m1_tile = 11'h009; m1_valid = 1'b1; m1_data = 16'hE000;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      m1_req = 1'b0;
      m1_data = 16'hE000 + 16'(sent[1]);
      tick();
    end
    idle_inputs();
    chk("rstmid_grant_m1", (g_log.size() >= 1) ? g_log[0] : -1, 1);
    chk("rstmid_first_addr", (wa_log.size() >= 1) ? {17'h0, wa_log[0]} : 32'hFFFFFFFF, 15'h0090);
    chk("rstmid_first_data", (wd_log.size() >= 1) ? {16'h0, wd_log[0]} : 32'hFFFFFFFF, 16'hE000);

    // Random traffic against the reference model.
    do_reset();
    rq[0] = 1'b0; rq[1] = 1'b0; tq[0] = '0; tq[1] = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (ph != 0 && own == k) rq[k] = 1'b0;
        else if (!rq[k]) begin
          if ($urandom_range(3) == 0) begin
            rq[k] = 1'b1;
            tq[k] = 11'($urandom);
          end
        end else if ($urandom_range(7) == 0) tq[k] = 11'($urandom);
      end
      m0_req = rq[0]; m1_req = rq[1]; m0_tile = tq[0]; m1_tile = tq[1];
      m0_valid = ($urandom_range(3) != 0); m1_valid = ($urandom_range(3) != 0);
      m0_data = 16'($urandom); m1_data = 16'($urandom);
      hold = ($urandom_range(4) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_tile_write_arbiter.md
# vram_tile_write_arbiter

Two-master write arbiter and burst sequencer for the VRAM tile memory write port. Each master uploads whole tiles: it requests with an 11-bit tile index, is granted exclusive use, and streams exactly 16 words of 16 bits over a valid/ready handshake. The block generates the registered `write_addr` / `write_data` / `write_enable` that drive the tile memory, with round-robin fairness between masters. It sits between the MCU register interface (master 0) and the ROM/DMA tile loader (master 1) on one side and the tile memory on the other.

## Interface
- `TILE_W`, 11: tile index width (2048 tiles); `write_addr` = `TILE_W`+4 = 15 bits
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1 each  burst request; held until grant
- `m0_tile`, `m1_tile`  in  11 each  tile index, sampled in the arbitration cycle
- `m0_valid`, `m1_valid`  in  1 each  data word valid
- `m0_data`, `m1_data`  in  16 each  data word
- `m0_ready`, `m1_ready`  out  1 each  word accepted when `valid && ready`
- `m0_grant`, `m1_grant`  out  1 each  high for the whole burst
- `m0_done`, `m1_done`  out  1 each  one-cycle pulse, burst complete
- `hold`  in  1  stall: forces both readies low, counter frozen
- `write_addr`  out  15  {tile, word}
- `write_data`  out  16  word to tile memory
- `write_enable`  out  1  one-cycle write strobe
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any `req`, choose a master, latch its tile index, clear the 4-bit word counter, and go to BURST. Without `req`, stay in IDLE.
- Priority pointer: starts at master 0 out of reset. If both masters request, the master the pointer names wins. With only one requester, that master wins regardless of the pointer. The pointer moves to the other master on entry to DONE.
- BURST:
  - `mX_grant` = 1 for the granted master only.
  - `mX_ready` = granted && !`hold`. The non-granted master's ready is always 0.
  - Each accepted word registers `write_addr` = {tile, counter}, `write_data` = word, and `write_enable` = 1 for the next cycle. It also increments the counter.
  - Accepting word 15 (counter 4'hF) goes to DONE. The counter wraps to 0 but is not used again.
- DONE: one cycle. `mX_done` = 1 and grant = 0. Go to IDLE.
- A master must deassert `req` in its DONE cycle. If `req` is still high in IDLE, it is a new request and is arbitrated normally.
- `valid` from the non-granted master is ignored, and no write results.
- `req` or `tile` changes during BURST are ignored. The tile index is latched.
- `hold` may assert at any cycle. It has no effect in IDLE or DONE.
- Reset (asserted at any time, including mid-burst): immediately go to IDLE. All outputs go to 0, counter = 0, pointer = master 0. The partial burst is abandoned, and words already written stay in memory.

## Timing
- Reset values: all outputs 0 (`ready`, `grant`, `done`, `write_enable`, `write_addr`, `write_data`, `busy`).
- Cycle T: IDLE with `req` high. T+1: BURST with `grant` = 1.
- Word accepted at cycle A: `write_enable` / `write_addr` / `write_data` are valid at A+1 (one-cycle registered latency).
- Last word accepted at cycle L: `done` = 1, grant = 0, and `write_enable` = 1 (the last write) at L+1. IDLE at L+2.
- Minimum burst with valid always high: 1 arbitration cycle + 16 data cycles + 1 DONE cycle = 18 cycles. Back-to-back bursts have no further gap.
- A stall from `hold` or from `valid` = 0 adds exactly one cycle per stalled cycle. `write_enable` is 0 on cycles following non-accepting cycles.

## Test plan
- Single burst: `m0_req`, tile 11'h005, 16 words 16'h1000..16'h100F, valid constant. Required response: 16 consecutive writes to addresses 15'h0050..15'h005F with the matching data, `m0_done` at cycle 18, and `busy` low at cycle 19.
- Simultaneous request after reset: both `req` high, tiles 11'h001 / 11'h002. Required response: master 0 is served first (addresses 15'h0010..15'h001F), then master 1 (addresses 15'h0020..15'h002F). Both `req` then stay high for a third burst, which goes to master 0.
- Hold stall: assert `hold` for 3 cycles after word 7 of a burst to tile 11'h7FF. Required response: no `write_enable` during the stall, the counter is frozen, addresses run 15'h7FF0..15'h7FFF with no gap or duplicate, and `done` arrives 3 cycles late.
- Foreign valid: master 1 drives `valid` with data 16'hDEAD during a master 0 burst. Required response: `m1_ready` = 0 throughout and 16'hDEAD is never written.
- Reset mid-burst: assert `reset_n` low after word 5. Required response: all outputs are 0 asynchronously. After release with only `m1_req` high, master 1 is granted and its first write goes to word 0.
- Valid gaps: drop `valid` on alternate cycles. Required response: 16 writes spread over 32 cycles, with `write_enable` pulses alternating.
